// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 keyboard receive bundle: raw line inputs plus the decoded scan-code outputs.
// The receiver takes the master side; the line driver / consumer takes the slave side.
interface ps2_keyboard_rx_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ps2_data;
    logic       ps2_hit;
    logic       ps2_err;

    modport master (
        input  ps2_clk,
        input  ps2_dat,
        output ps2_data,
        output ps2_hit,
        output ps2_err
    );

    modport slave (
        output ps2_clk,
        output ps2_dat,
        input  ps2_data,
        input  ps2_hit,
        input  ps2_err
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the PS/2 lines, deframes
// 11-bit frames and strobes ps2_hit with a valid scan code or ps2_err on a bad/aborted frame.
module ps2_keyboard_rx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 25000
) (
    input logic               clock,
    input logic               resetn,
    ps2_keyboard_rx_if.master bus
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [7:0]    data_q, data_d;
    logic          hit_q, hit_d;
    logic          err_q, err_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    // Filtered clock flips only after FILTER consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        hit_d   = 1'b0;
        err_d   = 1'b0;
        tcnt_d  = (fall_q || state_q == IDLE) ? '0 : tcnt_q + TW'(1);

        // A fall takes priority over a timeout landing on the same cycle.
        if (fall_q) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end
                end
                DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        data_d = shift_q;
                        hit_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tcnt_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            shift_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            fall_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            data_q   <= 8'h00;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            clk_s1_q <= bus.ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= bus.ps2_dat;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            fall_q   <= fall_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            data_q   <= data_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign bus.ps2_data = data_q;
    assign bus.ps2_hit  = hit_q;
    assign bus.ps2_err  = err_q;
endmodule
